// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, requester ownership
// and the default response timeout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Cycle counter for a pending memory access; expire flags the cycle in which
// the count would reach TIMEOUT, so a caller sees exactly TIMEOUT enabled cycles.
module arb_timeout_ctr
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CW-1:0] count;

  assign expire = enable && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the MIPS fetch and data paths onto one single-port memory with a
// req/ack handshake, one-cycle completion acks and a timeout error response.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_cs,
  input  logic          dm_w,
  input  logic          dm_r,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          err,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  arb_state_t state;
  owner_t     owner;
  logic       expire;
  logic       unused_dm_r;

  // Write wins whenever dm_w is set, and anything else is a read, so dm_r
  // never changes the decision.
  assign unused_dm_r = dm_r;

  assign stall = (if_req & ~if_ack) | (dm_cs & ~dm_ack);

  arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state != BUSY),
    .enable (state == BUSY),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dm_cs) begin
            owner     <= OWN_DM;
            mem_addr  <= dm_addr;
            mem_we    <= dm_w;
            mem_wdata <= dm_w ? dm_wdata : '0;
            mem_req   <= 1'b1;
            state     <= BUSY;
          end else if (if_req) begin
            owner     <= OWN_IF;
            mem_addr  <= if_addr;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_req   <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // A memory ack in the expiry cycle still counts as a normal response.
          if (mem_ack || expire) begin
            mem_req <= 1'b0;
            err     <= ~mem_ack;
            state   <= RESP;
            if (owner == OWN_DM) begin
              dm_ack   <= 1'b1;
              dm_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end
          end
        end
        RESP: begin
          if_ack   <= 1'b0;
          dm_ack   <= 1'b0;
          if_rdata <= '0;
          dm_rdata <= '0;
          err      <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port unified memory between the instruction-fetch path and the data-memory path of the MIPS core. It arbitrates each access, drives a req/ack handshake to the memory, and returns read data and a one-cycle ack to the winning requester. It also raises a pipeline stall while any requester waits, and converts a non-responding memory into an error response after a bounded timeout.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, max cycles in BUSY without mem_ack before error response (≥2)

Ports:
- clk  in  1  system clock; one clock domain for the whole block
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched word, valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse for fetch
- dm_cs  in  1  data request; held until dm_ack
- dm_w  in  1  data write
- dm_r  in  1  data read
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_rdata  out  DW  load data, valid while dm_ack=1
- dm_ack  out  1  one-cycle completion pulse for data
- err  out  1  response is a timeout error; coincident with if_ack or dm_ack
- stall  out  1  combinational: (if_req & ~if_ack) | (dm_cs & ~dm_ack)
- mem_req  out  1  memory request, held until mem_ack sampled
- mem_we  out  1  write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one cycle

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state IDLE.
- IDLE: if dm_cs=1, grant data. Else if if_req=1, grant fetch. Else stay. Data always beats fetch; fetch is never starved because the core stalls and re-issues no data access until the fetch completes.
- On grant, register owner, mem_addr, mem_we (1 for data with dm_w=1, else 0), and mem_wdata (dm_wdata for writes, 0 otherwise). Assert mem_req and go to BUSY.
- dm_cs=1 with dm_w=dm_r=0 is treated as a read. dm_w=dm_r=1 is treated as a write.
- BUSY: mem_req=1, and mem_* are stable. The timeout counter increments each cycle.
  - mem_ack=1: capture mem_rdata (0 for writes), set err=0, deassert mem_req, go to RESP.
  - Counter reaching TIMEOUT first: rdata=0, err=1, deassert mem_req, go to RESP.
- RESP: the owner's ack=1 for exactly one cycle, with rdata and err valid. Go to IDLE unconditionally.
- mem_ack in IDLE or RESP is ignored.
- Simultaneous mem_ack and timeout in the same cycle: mem_ack wins, err=0.
- Requester inputs are sampled only at grant. Changes during BUSY/RESP are ignored.
- Reset mid-operation:
  - All outputs return to reset values immediately.
  - The in-flight memory access is abandoned; memory must abort when mem_req drops.
  - No ack is issued for the abandoned access.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0, err=0, counter=0, state=IDLE.
- All outputs except stall are registered.
- Request seen in IDLE at cycle t: mem_req=1 from cycle t+1.
- mem_ack sampled at cycle t+k (k≥1): ack=1 at t+k+1, IDLE at t+k+2.
- Minimum transaction is 3 cycles, request to next grant opportunity.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then the error ack follows in the next cycle.
- The requester must drop or change its request in the cycle after its ack. A request still high in IDLE is a new access.

## Structure
- Shared package (mem_arb_pkg):
  - state enum: IDLE, BUSY, RESP
  - owner encoding: OWN_IF=0, OWN_DM=1
  - default TIMEOUT constant
- One natural sub-module: arb_timeout_ctr (clear/enable/expire, width $clog2(TIMEOUT+1)).
- Everything else lives in mem_port_arbiter.

## Test plan
- Fetch only: if_req, if_addr=0x0040_0000, mem_ack 2 cycles after mem_req with mem_rdata=0x2008_0005 -> if_ack one cycle, if_rdata=0x2008_0005, err=0, stall low after ack.
- Contention: if_req and dm_cs (dm_r=1, dm_addr=0x1001_0000) both rise at t -> data granted first (mem_addr=0x1001_0000), dm_ack, then fetch granted; if_ack follows 3+ cycles later.
- Store: dm_cs=1, dm_w=1, dm_wdata=0xDEAD_BEEF -> mem_we=1, mem_wdata=0xDEAD_BEEF held until mem_ack, dm_ack with dm_rdata=0.
- Timeout: TIMEOUT=4, mem_ack never asserted -> mem_req high for 4 cycles, then dm_ack=1, err=1, rdata=0. A late mem_ack in IDLE causes no ack.
- Race: mem_ack arrives in the same cycle the counter expires -> normal response, err=0, rdata=mem_rdata.
- Reset mid-BUSY: rst_n low while mem_req=1 -> mem_req, acks and data drop to 0 asynchronously, state is IDLE after release, and no spurious ack.
